// File: rtl/memoria_pkg.sv
// -----------------------------------------------------------------------------
// memoria_pkg
// Shared constants and types for the memoria write-port arbiter.
//   NREQ     : number of requesters competing for the write port
//   ADDR_W   : register-index width of the 16-entry register file
//   arb_state_e : FSM encoding (IDLE / WRITE / ACK)
//   PTR_RST  : reset value of the round-robin pointer, so that requester 0
//              has top priority after reset
// -----------------------------------------------------------------------------
package memoria_pkg;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_e;

    localparam logic [1:0] PTR_RST = 2'd3;

    // One-hot vector with only bit idx set; used for the per-requester pulses.
    function automatic logic [NREQ-1:0] grant_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/memoria_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin winner selection.
//   req_i   [3:0] : pending requests
//   ptr_i   [1:0] : last served requester; search starts at ptr_i+1
//   valid_o       : at least one request is pending
//   g_o     [1:0] : index of the first set request searching upward from
//                   ptr_i+1, wrapping modulo 4 (ptr_i itself is searched last)
// -----------------------------------------------------------------------------
module rr_pick
    import memoria_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic            valid_o,
    output logic [1:0]      g_o
);

    logic [1:0] cand_s;

    // Scan candidates from farthest to nearest so the nearest set request wins.
    always_comb begin
        valid_o = 1'b0;
        g_o     = ptr_i;
        cand_s  = ptr_i;
        for (int i = NREQ; i >= 1; i--) begin
            // offset 4 truncates to 0, i.e. the previous winner is checked last
            cand_s  = ptr_i + 2'(i);
            g_o     = req_i[cand_s] ? cand_s : g_o;
            valid_o = valid_o | req_i[cand_s];
        end
    end

endmodule

// File: rtl/memoria_wr_arbiter.sv
// -----------------------------------------------------------------------------
// memoria_wr_arbiter
// Round-robin sequencer for the single write port (w, select_register, s) of
// the 16x16 register file `memoria`. One request is granted at a time; the
// granted request gets exactly one write cycle followed by a one-cycle ack.
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   synchronous, active-low reset
//   req      [3:0]   in   request per requester, held high until ack
//   req_addr [15:0]  in   4-bit register index per requester (k at [4k+3:4k])
//   req_data [4N-1:0] in  write data per requester (k at [Nk+N-1:Nk])
//   ack      [3:0]   out  one-cycle completion pulse to the granted requester
//   err      [3:0]   out  one-cycle protect-violation pulse, coincident with ack
//   busy             out  high whenever the FSM is not in IDLE
//   w                out  write enable to `memoria`
//   select_register  out  register index to `memoria`
//   s        [N-1:0] out  write data to `memoria`
//
// Build option
//   ARB_WRITE_PROTECT_EN : when defined, a grant whose register index has its
//   PROT_MASK bit set runs through WRITE with w held low and reports err.
//   When undefined, PROT_MASK is ignored and err stays 0.
//
// Timing: req sampled at edge E -> w high in the cycle after E -> ack high in
// the cycle after E+1 -> back in IDLE after E+2. All outputs are registered.
// -----------------------------------------------------------------------------
module memoria_wr_arbiter
    import memoria_pkg::*;
#(
    parameter int          N         = 16,
    parameter int          NREQ      = memoria_pkg::NREQ,
    parameter logic [15:0] PROT_MASK = 16'hE000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*N-1:0]      req_data,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        err,
    output logic                   busy,
    output logic                   w,
    output logic [ADDR_W-1:0]      select_register,
    output logic [N-1:0]           s
);

    arb_state_e          state_q;
    logic [1:0]          ptr_q;
    logic [1:0]          grant_q;
    logic                prot_q;
    logic [NREQ-1:0]     ack_q;
    logic [NREQ-1:0]     err_q;
    logic                busy_q;
    logic                w_q;
    logic [ADDR_W-1:0]   sel_q;
    logic [N-1:0]        s_q;

    logic                pick_valid_s;
    logic [1:0]          pick_g_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [N-1:0]        win_data_s;
    logic                prot_s;

    rr_pick u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .g_o     (pick_g_s)
    );

    assign win_addr_s = req_addr[pick_g_s*ADDR_W +: ADDR_W];
    assign win_data_s = req_data[pick_g_s*N +: N];

`ifdef ARB_WRITE_PROTECT_EN
    assign prot_s = PROT_MASK[win_addr_s];
`else
    logic unused_prot_s;
    assign prot_s        = 1'b0;
    assign unused_prot_s = ^PROT_MASK;
`endif

    // Arbitration FSM with pointer, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            grant_q <= 2'd0;
            prot_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            w_q     <= 1'b0;
            sel_q   <= '0;
            s_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= '0;
                    err_q <= '0;
                    if (pick_valid_s) begin
                        // Latch the winner's request; later changes on the
                        // request bus no longer affect this transaction.
                        grant_q <= pick_g_s;
                        sel_q   <= win_addr_s;
                        s_q     <= win_data_s;
                        prot_q  <= prot_s;
                        w_q     <= ~prot_s;
                        busy_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        w_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    w_q     <= 1'b0;
                    ack_q   <= grant_onehot(grant_q);
                    err_q   <= prot_q ? grant_onehot(grant_q) : '0;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    busy_q  <= 1'b0;
                    // Served requester drops to lowest priority next round.
                    ptr_q   <= grant_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    busy_q  <= 1'b0;
                    w_q     <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack             = ack_q;
    assign err             = err_q;
    assign busy            = busy_q;
    assign w               = w_q;
    assign select_register = sel_q;
    assign s               = s_q;

endmodule

// File: tb/tb_memoria_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memoria_wr_arbiter
// Scoreboard bench for memoria_wr_arbiter. A transaction-level reference model
// (pending set, rotating priority, fixed write/ack offsets, register-file
// contents) queues the expected writes and acks; an independent monitor pops
// and compares whenever the DUT shows w or ack. A local register file stands
// in for `memoria` and is compared against the model's contents.
// -----------------------------------------------------------------------------
module tb_memoria_wr_arbiter;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        busy;
    logic        w;
    logic [3:0]  select_register;
    logic [15:0] s;

    always #5 clk = ~clk;

    memoria_wr_arbiter #(.N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .ack             (ack),
        .err             (err),
        .busy            (busy),
        .w               (w),
        .select_register (select_register),
        .s               (s)
    );

`ifdef ARB_WRITE_PROTECT_EN
    bit prot_on = 1'b1;
`else
    bit prot_on = 1'b0;
`endif
    logic [15:0] prot_mask = 16'hE000;

    int   cyc   = 0;
    logic rst_e = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_e <= rst;

    // Stand-in for memoria: async reset from ~rst, written on w.
    logic [15:0] mem_tb [16];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem_tb[i] <= 16'h0;
        end else if (w) begin
            mem_tb[select_register] <= s;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int stamp; logic [3:0] addr; logic [15:0] data; } wexp_t;
    typedef struct { int stamp; int k; bit err; } aexp_t;

    wexp_t wq [$];
    aexp_t aq [$];
    int    dut_acks [$];

    // Reference model state (transaction level)
    bit          inflight  = 1'b0;
    int          fk, fwr, fack;
    bit          fprot;
    logic [3:0]  faddr;
    logic [15:0] fdata;
    int          ptr_m     = 3;
    int          next_free = 0;
    logic [15:0] mem_m [16];

    // Called once per cycle right after the inputs for the next edge are set.
    task automatic model_step();
        int nxt;
        int g;
        logic [3:0]  a;
        logic [15:0] d;
        nxt = cyc + 1;
        if (rst !== 1'b1) begin
            wq.delete();
            aq.delete();
            inflight  = 1'b0;
            ptr_m     = 3;
            next_free = nxt + 1;
            for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
        end else begin
            if (inflight && cyc == fwr && !fprot) mem_m[faddr] = fdata;
            if (inflight && cyc == fack + 1) begin
                req[fk]  = 1'b0;
                ptr_m    = fk;
                inflight = 1'b0;
            end
            if (!inflight && nxt >= next_free && req != 4'b0) begin
                g = -1;
                for (int i = 1; i <= 4; i++)
                    if (g < 0 && req[(ptr_m + i) % 4]) g = (ptr_m + i) % 4;
                a = req_addr[g*4 +: 4];
                d = req_data[g*16 +: 16];
                inflight  = 1'b1;
                fk        = g;
                fwr       = nxt;
                fack      = nxt + 1;
                faddr     = a;
                fdata     = d;
                fprot     = prot_on && prot_mask[a];
                next_free = nxt + 3;
                if (!fprot) wq.push_back('{stamp: nxt, addr: a, data: d});
                aq.push_back('{stamp: nxt + 1, k: g, err: fprot});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            model_step();
        end
    endtask

    function automatic int count_acks(input int k);
        int c = 0;
        foreach (dut_acks[i]) if (dut_acks[i] == k) c++;
        return c;
    endfunction

    // Monitor: compares DUT outputs against the queued expectations.
    wexp_t       we_m;
    aexp_t       ae_m;
    bit          be_m;
    int          ak_m;
    logic [3:0]  one_m = 4'b0001;
    logic [3:0]  exp_v;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_e)
                chk({ack, err, busy, w, select_register, s} === 30'b0, "reset_outputs",
                    {ack, err, busy, w, select_register, s}, 64'h0);
            be_m = (aq.size() > 0) && (aq[0].stamp == cyc || aq[0].stamp == cyc + 1);
            chk(busy === be_m, "busy", busy, be_m);
            if (w === 1'b1) begin
                if (wq.size() == 0) begin
                    chk(1'b0, "spurious_write", select_register, 64'h0);
                end else begin
                    we_m = wq.pop_front();
                    chk(we_m.stamp == cyc, "write_cycle", cyc, we_m.stamp);
                    chk(select_register === we_m.addr, "write_addr", select_register, we_m.addr);
                    chk(s === we_m.data, "write_data", s, we_m.data);
                end
            end else if (wq.size() > 0 && wq[0].stamp <= cyc) begin
                we_m = wq.pop_front();
                chk(1'b0, "missing_write", 64'h0, we_m.addr);
            end
            if (ack !== 4'b0) begin
                ak_m = 0;
                for (int i = 0; i < 4; i++) if (ack[i]) ak_m = i;
                dut_acks.push_back(ak_m);
                if (aq.size() == 0) begin
                    chk(1'b0, "spurious_ack", ack, 64'h0);
                end else begin
                    ae_m  = aq.pop_front();
                    exp_v = one_m << ae_m.k;
                    chk(ae_m.stamp == cyc, "ack_cycle", cyc, ae_m.stamp);
                    chk(ack === exp_v, "ack_vector", ack, exp_v);
                    chk(err === (ae_m.err ? exp_v : 4'b0), "err_vector", err, ae_m.err ? exp_v : 4'b0);
                end
            end else begin
                if (err !== 4'b0) chk(1'b0, "err_without_ack", err, 64'h0);
                if (aq.size() > 0 && aq[0].stamp <= cyc) begin
                    ae_m = aq.pop_front();
                    chk(1'b0, "missing_ack", 64'h0, ae_m.k);
                end
            end
        end
    end

    int n_before;

    initial begin
        rst      = 1'b0;
        req      = 4'hF;
        req_addr = 16'h3210;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Reset held with all requests pending, then fairness run
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        model_step();
        for (int t = 0; t < 80 && dut_acks.size() < 12; t++) begin
            @(negedge clk);
            req = 4'hF;
            model_step();
        end
        chk(dut_acks.size() >= 12, "fairness_ack_count", dut_acks.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < dut_acks.size()) chk(dut_acks[i] == i % 4, "fairness_order", dut_acks[i], i % 4);
        repeat (6) begin
            @(negedge clk);
            req = 4'h0;
            model_step();
        end

        // Single write from requester 1
        @(negedge clk);
        req_addr[7:4]   = 4'h5;
        req_data[31:16] = 16'hABCD;
        req             = 4'b0010;
        model_step();
        idle(6);
        chk(mem_tb[5] === 16'hABCD, "single_write_r6", mem_tb[5], 16'hABCD);

        // Data changed after the grant must not reach the write
        @(negedge clk);
        req_addr[11:8]  = 4'h3;
        req_data[47:32] = 16'h1111;
        req             = 4'b0100;
        model_step();
        @(negedge clk);
        req_data[47:32] = 16'h2222;
        model_step();
        idle(5);
        chk(mem_tb[3] === 16'h1111, "change_after_grant", mem_tb[3], 16'h1111);

        // Reset in the WRITE cycle aborts; pending request is re-served
        n_before = count_acks(0);
        @(negedge clk);
        req_addr[3:0]  = 4'h7;
        req_data[15:0] = 16'h5A5A;
        req            = 4'b0001;
        model_step();
        @(negedge clk);
        rst = 1'b0;
        model_step();
        @(negedge clk);
        rst = 1'b1;
        model_step();
        idle(6);
        chk(mem_tb[7] === 16'h5A5A, "reset_mid_write_regrant", mem_tb[7], 16'h5A5A);
        chk(mem_tb[5] === 16'h0, "reset_clears_regfile", mem_tb[5], 16'h0);
        chk(count_acks(0) - n_before == 1, "reset_mid_write_ack_count", count_acks(0) - n_before, 1);

        // Protected index (write suppressed only when the option is built in)
        @(negedge clk);
        req_addr[15:12] = 4'hE;
        req_data[63:48] = 16'h0F0F;
        req             = 4'b1000;
        model_step();
        idle(6);
        chk(mem_tb[14] === (prot_on ? 16'h0 : 16'h0F0F), "protect_r15", mem_tb[14],
            prot_on ? 16'h0 : 16'h0F0F);

        // Randomized traffic
        repeat (400) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    req_addr[k*4 +: 4]   = 4'($urandom_range(0, 15));
                    req_data[k*16 +: 16] = 16'($urandom);
                end
                if (!(inflight && fk == k)) begin
                    if (req[k] == 1'b0) req[k] = ($urandom_range(0, 2) == 0);
                    else if ($urandom_range(0, 9) == 0) req[k] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[k] = 1'b0;
                end
            end
            model_step();
        end

        repeat (12) begin
            @(negedge clk);
            req = 4'h0;
            model_step();
        end
        chk(wq.size() == 0, "writes_outstanding", wq.size(), 0);
        chk(aq.size() == 0, "acks_outstanding", aq.size(), 0);
        for (int i = 0; i < 16; i++)
            chk(mem_tb[i] === mem_m[i], "regfile_contents", mem_tb[i], mem_m[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
